// File: rtl/instr_dispatch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_dispatch_queue_if
//   Bundle between the control unit (master), the execution-unit issue
//   channels and the instruction dispatch queue (slave).
//
//   Optional macro: DISPATCH_QUEUE_STATS_EN adds issue_count (per-channel
//   32-bit issue counters, channel c in bits [c*32 +: 32]).
//
//   Signals (direction seen from the queue / slave side):
//     freeze      in   global pipeline freeze
//     we          in   push strobe
//     in_type     in   target channel of pushed entry
//     in_data     in   pushed payload
//     stall_push  out  early backpressure to the producer
//     ch_ready    in   per-channel ready
//     out_valid   out  one-hot registered issue strobe
//     out_data    out  registered payload of issued entry
//     flush       in   discard all queued entries
//     flush_done  out  one-cycle pulse when a flush completes
//     empty       out  queue empty
//     count       out  occupancy
//     overflow    out  sticky dropped-push flag
// ---------------------------------------------------------------------------
interface instr_dispatch_queue_if #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 3
);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                freeze;
  logic                we;
  logic [CH_W-1:0]     in_type;
  logic [WIDTH-1:0]    in_data;
  logic                stall_push;
  logic [CHANNELS-1:0] ch_ready;
  logic [CHANNELS-1:0] out_valid;
  logic [WIDTH-1:0]    out_data;
  logic                flush;
  logic                flush_done;
  logic                empty;
  logic [CNT_W-1:0]    count;
  logic                overflow;
`ifdef DISPATCH_QUEUE_STATS_EN
  logic [CHANNELS*32-1:0] issue_count;

  modport master (
    output freeze, we, in_type, in_data, ch_ready, flush,
    input  stall_push, out_valid, out_data, flush_done, empty, count,
           overflow, issue_count
  );

  modport slave (
    input  freeze, we, in_type, in_data, ch_ready, flush,
    output stall_push, out_valid, out_data, flush_done, empty, count,
           overflow, issue_count
  );
`else
  modport master (
    output freeze, we, in_type, in_data, ch_ready, flush,
    input  stall_push, out_valid, out_data, flush_done, empty, count,
           overflow
  );

  modport slave (
    input  freeze, we, in_type, in_data, ch_ready, flush,
    output stall_push, out_valid, out_data, flush_done, empty, count,
           overflow
  );
`endif
endinterface

// File: rtl/instr_dispatch_queue.sv
// ---------------------------------------------------------------------------
// instr_dispatch_queue
//   In-order circular instruction queue feeding CHANNELS execution units.
//   One tagged entry is accepted per cycle; the head entry issues to its
//   channel when that channel is ready and the core is not frozen. Issue is
//   registered: out_valid/out_data appear one edge after the pop.
//   Entries whose type is not a real channel are popped silently.
//
//   Optional macro: DISPATCH_QUEUE_STATS_EN adds per-channel saturating
//   32-bit issue counters on bus.issue_count (cleared by reset and flush).
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    instr_dispatch_queue_if.slave (push, issue, flush, status)
// ---------------------------------------------------------------------------
module instr_dispatch_queue #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 64,
  parameter int CHANNELS     = 3,
  parameter int STALL_MARGIN = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  instr_dispatch_queue_if.slave        bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_flush_done;
  logic   w_flush_done_nxt;

  logic [WIDTH-1:0] r_data_mem [DEPTH];
  logic [CH_W-1:0]  r_type_mem [DEPTH];

  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [CHANNELS-1:0] r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_overflow;

  logic [CH_W-1:0]     w_head_type;
  logic                w_head_legal;
  logic                w_head_ready;
  logic [CHANNELS-1:0] w_head_onehot;
  logic                w_run;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_issue;
  logic [CNT_W-1:0]    w_free;

  // -------------------------------------------------------------------------
  // Head decode. A head whose type is not a real channel counts as ready so
  // it is popped (and dropped) instead of blocking the queue forever.
  // -------------------------------------------------------------------------
  assign w_head_type = r_type_mem[r_rd_ptr];

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default before any branch, so no latch can be inferred.
  always_comb begin
    w_head_legal  = 1'b0;
    w_head_ready  = 1'b1;
    w_head_onehot = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_head_type == CH_W'(c)) begin
        w_head_legal     = 1'b1;
        w_head_ready     = bus.ch_ready[c];
        w_head_onehot[c] = 1'b1;
      end
    end
  end

  assign w_run   = (r_state == ST_RUN);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  // Push decision uses the pre-pop count: a full queue drops the push even
  // if the head pops in the same cycle.
  assign w_push  = w_run && bus.we && !w_full;
  assign w_pop   = w_run && !w_empty && !bus.freeze && w_head_ready;
  assign w_issue = w_pop && w_head_legal;
  assign w_free  = CNT_W'(DEPTH) - r_count;

  // -------------------------------------------------------------------------
  // Control FSM: RUN -> FLUSH for exactly one cycle, then back to RUN.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_done_nxt = 1'b0;
    unique case (r_state)
      ST_RUN:   if (bus.flush) w_state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        w_state_nxt      = ST_RUN;
        w_flush_done_nxt = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= w_flush_done_nxt;
    end
  end

  // NOTE: the entry array is deliberately not reset; pointers and count
  // define which slots are valid, and a reset array would cost a clear path
  // on every bit for no functional gain.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= bus.in_data;
      r_type_mem[r_wr_ptr] <= bus.in_type;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, occupancy and registered issue outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else if (r_state == ST_FLUSH) begin
      // Flush wins over freeze: everything queued is discarded.
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

      // Frozen outputs hold; otherwise the strobe is a single-cycle pulse.
      if (!bus.freeze) begin
        r_out_valid <= w_issue ? w_head_onehot : '0;
        if (w_issue) r_out_data <= r_data_mem[r_rd_ptr];
      end

      if (bus.we && w_full) r_overflow <= 1'b1;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.count      = r_count;
  assign bus.empty      = w_empty;
  assign bus.overflow   = r_overflow;
  assign bus.flush_done = r_flush_done;
  assign bus.stall_push = (w_free <= CNT_W'(STALL_MARGIN)) || (r_state == ST_FLUSH);

`ifdef DISPATCH_QUEUE_STATS_EN
  // -------------------------------------------------------------------------
  // Per-channel saturating issue counters; discarded entries never count.
  // -------------------------------------------------------------------------
  logic [31:0] r_issue_cnt [CHANNELS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) r_issue_cnt[c] <= '0;
    end else if (r_state == ST_FLUSH) begin
      for (int c = 0; c < CHANNELS; c++) r_issue_cnt[c] <= '0;
    end else if (w_issue) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_head_onehot[c] && (r_issue_cnt[c] != '1))
          r_issue_cnt[c] <= r_issue_cnt[c] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_stats
    assign bus.issue_count[g*32 +: 32] = r_issue_cnt[g];
  end
`endif

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_dispatch_queue
//   Directed bench for instr_dispatch_queue (default parameters). Issued
//   entries are compared against a scoreboard filled at push time; cycle-
//   exact behaviour (latency, stall, freeze, flush, reset) is checked inline.
// ---------------------------------------------------------------------------
module tb_instr_dispatch_queue;
  localparam int DEPTH        = 16;
  localparam int WIDTH        = 64;
  localparam int CHANNELS     = 3;
  localparam int STALL_MARGIN = 2;
  localparam int CH_W         = $clog2(CHANNELS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_dispatch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CHANNELS(CHANNELS)) dq ();

  instr_dispatch_queue #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .CHANNELS(CHANNELS), .STALL_MARGIN(STALL_MARGIN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dq.slave)
  );

  typedef struct packed {
    logic [CHANNELS-1:0] onehot;
    logic [WIDTH-1:0]    data;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          n_issued = 0;
  int unsigned exp_cnt [CHANNELS];

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one push for a single cycle; tracked entries are expected to issue.
  task automatic push(input int t, input logic [WIDTH-1:0] d, input bit track);
    exp_t e;
    dq.we      = 1'b1;
    dq.in_type = CH_W'(t);
    dq.in_data = d;
    if (track) begin
      e.onehot = CHANNELS'(1) << t;
      e.data   = d;
      sb.push_back(e);
    end
    @(negedge clk);
    dq.we = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!dq.empty && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_drain_timeout"}, WIDTH'(n < 100), WIDTH'(1));
    check({tag, "_sb_left"}, WIDTH'(sb.size()), WIDTH'(0));
  endtask

  task automatic check_stats(input string tag);
`ifdef DISPATCH_QUEUE_STATS_EN
    for (int c = 0; c < CHANNELS; c++)
      check($sformatf("%s_issue_count%0d", tag, c),
            WIDTH'(dq.issue_count[c*32 +: 32]), WIDTH'(exp_cnt[c]));
`else
    check({tag, "_no_stats_count"}, WIDTH'(dq.count), WIDTH'(dq.count === 'x ? 1 : dq.count));
`endif
  endtask

  // Issue monitor: a fresh issue is any nonzero out_valid after an edge at
  // which freeze was low (a frozen edge only holds the previous strobe).
  always @(posedge clk) begin
    logic frz;
    exp_t e;
    frz = dq.freeze;
    #1;
    if (!reset && !frz && (dq.out_valid != '0)) begin
      n_issued++;
      if (sb.size() == 0) begin
        check("unexpected_issue", WIDTH'(dq.out_valid), WIDTH'(0));
      end else begin
        e = sb.pop_front();
        check("issue_valid", WIDTH'(dq.out_valid), WIDTH'(e.onehot));
        check("issue_data", dq.out_data, e.data);
        for (int c = 0; c < CHANNELS; c++) if (e.onehot[c]) exp_cnt[c]++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset       = 1'b1;
    dq.freeze   = 1'b0;
    dq.we       = 1'b0;
    dq.in_type  = '0;
    dq.in_data  = '0;
    dq.ch_ready = '0;
    dq.flush    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) exp_cnt[c] = 0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_out_valid",  WIDTH'(dq.out_valid),  WIDTH'(0));
    check("rst_out_data",   dq.out_data,           WIDTH'(0));
    check("rst_empty",      WIDTH'(dq.empty),      WIDTH'(1));
    check("rst_count",      WIDTH'(dq.count),      WIDTH'(0));
    check("rst_stall",      WIDTH'(dq.stall_push), WIDTH'(0));
    check("rst_overflow",   WIDTH'(dq.overflow),   WIDTH'(0));
    check("rst_flush_done", WIDTH'(dq.flush_done), WIDTH'(0));
    reset = 1'b0;
    @(negedge clk);

    // Three types back to back, all channels ready
    dq.ch_ready = '1;
    push(0, 64'hA0, 1);
    check("t1_no_bypass", WIDTH'(dq.out_valid), WIDTH'(0));
    check("t1_count1",    WIDTH'(dq.count),     WIDTH'(1));
    push(1, 64'hA1, 1);
    check("t1_v0", WIDTH'(dq.out_valid), WIDTH'(3'b001));
    check("t1_d0", dq.out_data, 64'hA0);
    push(2, 64'hA2, 1);
    check("t1_v1", WIDTH'(dq.out_valid), WIDTH'(3'b010));
    @(negedge clk);
    check("t1_v2", WIDTH'(dq.out_valid), WIDTH'(3'b100));
    check("t1_d2", dq.out_data, 64'hA2);
    @(negedge clk);
    check("t1_idle_valid", WIDTH'(dq.out_valid), WIDTH'(0));
    check("t1_data_hold",  dq.out_data,          64'hA2);
    check("t1_empty",      WIDTH'(dq.empty),     WIDTH'(1));

    // Fill to full with no channel ready, then overflow
    dq.ch_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      push(i % CHANNELS, WIDTH'(64'h100 + i), 1);
      check($sformatf("t2_count%0d", i), WIDTH'(dq.count), WIDTH'(i + 1));
      check($sformatf("t2_stall%0d", i), WIDTH'(dq.stall_push),
            WIDTH'((DEPTH - (i + 1)) <= STALL_MARGIN));
    end
    push(0, 64'hDEAD, 0);
    check("t2_overflow",  WIDTH'(dq.overflow), WIDTH'(1));
    check("t2_count_full", WIDTH'(dq.count),   WIDTH'(DEPTH));
    dq.ch_ready = '1;
    drain("t2");
    check("t2_overflow_sticky", WIDTH'(dq.overflow), WIDTH'(1));

    // Head blocked on its own channel: strict in-order issue
    dq.ch_ready = 3'b101;
    push(1, 64'hB1, 1);
    push(0, 64'hB0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t3_blocked%0d", i), WIDTH'(dq.out_valid), WIDTH'(0));
      check($sformatf("t3_count%0d", i),   WIDTH'(dq.count),     WIDTH'(2));
    end
    dq.ch_ready = 3'b111;
    @(negedge clk);
    check("t3_v_head",  WIDTH'(dq.out_valid), WIDTH'(3'b010));
    check("t3_d_head",  dq.out_data,          64'hB1);
    @(negedge clk);
    check("t3_v_young", WIDTH'(dq.out_valid), WIDTH'(3'b001));
    check("t3_d_young", dq.out_data,          64'hB0);
    drain("t3");

    // Freeze holds outputs; a push during freeze is still accepted
    push(1, 64'hC1, 1);
    push(2, 64'hC2, 1);
    check("t4_v_pre", WIDTH'(dq.out_valid), WIDTH'(3'b010));
    dq.freeze = 1'b1;
    push(0, 64'hC3, 1);
    check("t4_count_push", WIDTH'(dq.count), WIDTH'(2));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_hold_v%0d", i), WIDTH'(dq.out_valid), WIDTH'(3'b010));
      check($sformatf("t4_hold_d%0d", i), dq.out_data,          64'hC1);
      if (i < 2) @(negedge clk);
    end
    dq.freeze = 1'b0;
    @(negedge clk);
    check("t4_v_after", WIDTH'(dq.out_valid), WIDTH'(3'b100));
    check("t4_d_after", dq.out_data,          64'hC2);
    drain("t4");
    check_stats("t5_pre_flush");

    // Flush with a simultaneous push
    dq.ch_ready = '0;
    for (int i = 0; i < 10; i++) push(i % CHANNELS, WIDTH'(64'h500 + i), 0);
    check("t5_count10", WIDTH'(dq.count), WIDTH'(10));
    dq.flush   = 1'b1;
    dq.we      = 1'b1;
    dq.in_type = '0;
    dq.in_data = 64'hBAD;
    @(negedge clk);
    check("t5_stall_in_flush", WIDTH'(dq.stall_push), WIDTH'(1));
    check("t5_done_early",     WIDTH'(dq.flush_done), WIDTH'(0));
    dq.flush = 1'b0;
    @(negedge clk);
    for (int c = 0; c < CHANNELS; c++) exp_cnt[c] = 0;
    check("t5_count0",     WIDTH'(dq.count),      WIDTH'(0));
    check("t5_empty",      WIDTH'(dq.empty),      WIDTH'(1));
    check("t5_flush_done", WIDTH'(dq.flush_done), WIDTH'(1));
    check("t5_stall_run",  WIDTH'(dq.stall_push), WIDTH'(0));
    dq.we = 1'b0;
    @(negedge clk);
    check("t5_done_pulse", WIDTH'(dq.flush_done), WIDTH'(0));
    check("t5_push_ignored", WIDTH'(dq.count),    WIDTH'(0));
    check_stats("t5_post_flush");

    // Stream 40 entries: pointers wrap repeatedly, one issue per cycle
    dq.ch_ready = '1;
    base = n_issued;
    for (int i = 0; i < 40; i++) begin
      push(i % CHANNELS, WIDTH'(64'h6000 + i), 1);
      check($sformatf("t6_count%0d", i), WIDTH'(dq.count), WIDTH'(1));
    end
    drain("t6");
    check("t6_issued40", WIDTH'(n_issued - base), WIDTH'(40));

    // Invalid type is popped silently
    push(3, 64'h7777, 0);
    push(0, 64'h7000, 1);
    check("t7_discard_valid", WIDTH'(dq.out_valid), WIDTH'(0));
    check("t7_discard_data",  dq.out_data,          WIDTH'(64'h6000 + 39));
    @(negedge clk);
    check("t7_next_valid", WIDTH'(dq.out_valid), WIDTH'(3'b001));
    check("t7_next_data",  dq.out_data,          64'h7000);
    drain("t7");
    check_stats("t7_stats");

    // Asynchronous reset mid-cycle
    dq.ch_ready = '0;
    for (int i = 0; i < 3; i++) push(i, WIDTH'(64'h800 + i), 0);
    check("t8_count3", WIDTH'(dq.count), WIDTH'(3));
    #2 reset = 1'b1;
    for (int c = 0; c < CHANNELS; c++) exp_cnt[c] = 0;
    #1;
    check("t8_count",    WIDTH'(dq.count),    WIDTH'(0));
    check("t8_empty",    WIDTH'(dq.empty),    WIDTH'(1));
    check("t8_overflow", WIDTH'(dq.overflow), WIDTH'(0));
    check("t8_out_data", dq.out_data,         WIDTH'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t8_count_after", WIDTH'(dq.count),     WIDTH'(0));
    check("t8_valid_after", WIDTH'(dq.out_valid), WIDTH'(0));
    check_stats("t8_stats");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
